// File: rtl/y_demux2_buf_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | y_demux2_buf_if : input stream + two output streams of y_demux2_buf   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+

interface y_demux2_buf_if #(
  parameter int W = 2
);
  logic         in_valid;
  logic         in_ready;
  logic         in_sel;
  logic [W-1:0] in_data;

  logic         out0_valid;
  logic         out0_ready;
  logic [W-1:0] out0_data;

  logic         out1_valid;
  logic         out1_ready;
  logic [W-1:0] out1_data;

  modport master (
    output in_valid, in_sel, in_data, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

  modport slave (
    input  in_valid, in_sel, in_data, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
  );
endinterface

`default_nettype wire

// File: rtl/y_demux2_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | y_demux2_buf : 1-to-2 demux routing by in_sel into two private FIFOs  |
// | Optional pop counters cnt0/cnt1 with macro Y_DEMUX_CNT_EN. Rev 1.0    |
// +----------------------------------------------------------------------+

module y_demux2_buf #(
  parameter int W     = 2,
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rstn,
  y_demux2_buf_if.slave  bus
`ifdef Y_DEMUX_CNT_EN
  ,
  output logic [7:0]     cnt0,
  output logic [7:0]     cnt1
`endif
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [1:0][AW:0] r_wptr;
  logic [1:0][AW:0] r_rptr;
  logic [W-1:0]     r_mem [2][DEPTH];

  logic [1:0]       w_full;
  logic [1:0]       w_empty;
  logic [1:0]       w_push;
  logic [1:0]       w_pop;
  logic [W-1:0]     w_head [2];
  logic             w_in_ready;

  always_comb begin
    w_full    = '0;
    w_empty   = '0;
    w_head[0] = '0;
    w_head[1] = '0;
    for (int n = 0; n < 2; n++) begin
      w_empty[n] = (r_wptr[n] == r_rptr[n]);
      w_full[n]  = (r_wptr[n][AW] != r_rptr[n][AW]) &&
                   (r_wptr[n][AW-1:0] == r_rptr[n][AW-1:0]);
      w_head[n]  = w_empty[n] ? '0 : r_mem[n][r_rptr[n][AW-1:0]];
    end
  end

  // Readiness depends only on in_sel and stored occupancy, never on outN_ready.
  assign w_in_ready = ~w_full[bus.in_sel];

  assign w_push[0] = bus.in_valid & w_in_ready & ~bus.in_sel;
  assign w_push[1] = bus.in_valid & w_in_ready &  bus.in_sel;
  assign w_pop[0]  = ~w_empty[0] & bus.out0_ready;
  assign w_pop[1]  = ~w_empty[1] & bus.out1_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (w_push[n]) r_wptr[n] <= r_wptr[n] + (AW+1)'(1);
        if (w_pop[n])  r_rptr[n] <= r_rptr[n] + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (w_push[n]) r_mem[n][r_wptr[n][AW-1:0]] <= bus.in_data;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out0_valid = ~w_empty[0];
  assign bus.out0_data  = w_head[0];
  assign bus.out1_valid = ~w_empty[1];
  assign bus.out1_data  = w_head[1];

`ifdef Y_DEMUX_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt0 <= 8'd0;
      cnt1 <= 8'd0;
    end else begin
      if (w_pop[0]) cnt0 <= cnt0 + 8'd1;
      if (w_pop[1]) cnt1 <= cnt1 + 8'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_y_demux2_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_y_demux2_buf : directed + random stimulus against a queue model    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+

module tb_y_demux2_buf;

  localparam int W     = 2;
  localparam int DEPTH = 2;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [7:0]   cnt0_m;
  logic [7:0]   cnt1_m;

  y_demux2_buf_if #(.W(W)) bus ();

`ifdef Y_DEMUX_CNT_EN
  logic [7:0] cnt0;
  logic [7:0] cnt1;
`endif

  y_demux2_buf #(.W(W), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef Y_DEMUX_CNT_EN
    ,
    .cnt0 (cnt0),
    .cnt1 (cnt1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic sel);
    logic exp_rdy;
    exp_rdy = sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    check({tag, ".in_ready"},   bus.in_ready,   exp_rdy);
    check({tag, ".out0_valid"}, bus.out0_valid, q0.size() != 0);
    check({tag, ".out0_data"},  bus.out0_data,  (q0.size() != 0) ? q0[0] : '0);
    check({tag, ".out1_valid"}, bus.out1_valid, q1.size() != 0);
    check({tag, ".out1_data"},  bus.out1_data,  (q1.size() != 0) ? q1[0] : '0);
`ifdef Y_DEMUX_CNT_EN
    check({tag, ".cnt0"}, cnt0, cnt0_m);
    check({tag, ".cnt1"}, cnt1, cnt1_m);
`endif
  endtask

  // Called at posedge+1; drives one cycle, checks at the negedge, updates the model.
  task automatic cycle(input string tag, input logic v, input logic s,
                       input logic [W-1:0] d, input logic r0, input logic r1);
    logic acc, p0, p1;
    bus.in_valid   = v;
    bus.in_sel     = s;
    bus.in_data    = d;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
    @(negedge clk);
    check_outputs(tag, s);
    acc = v && (s ? (q1.size() < DEPTH) : (q0.size() < DEPTH));
    p0  = r0 && (q0.size() != 0);
    p1  = r1 && (q1.size() != 0);
    @(posedge clk);
    #1;
    if (p0) begin void'(q0.pop_front()); cnt0_m = cnt0_m + 8'd1; end
    if (p1) begin void'(q1.pop_front()); cnt1_m = cnt1_m + 8'd1; end
    if (acc) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
    end
  endtask

  // Asserts reset away from the clock edge and checks outputs before any edge.
  task automatic do_reset(input string tag);
    bus.in_valid   = 1'b0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    #2 rstn = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    cnt0_m = 8'd0;
    cnt1_m = 8'd0;
    check_outputs(tag, bus.in_sel);
    @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    cnt0_m         = 8'd0;
    cnt1_m         = 8'd0;
    rstn           = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_sel     = 1'b0;
    bus.in_data    = '0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;

    do_reset("reset0");
    cycle("idle", 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);

    // Routing with both consumers ready
    cycle("route_a", 1'b1, 1'b0, 2'b01, 1'b1, 1'b1);
    cycle("route_b", 1'b1, 1'b1, 2'b10, 1'b1, 1'b1);
    cycle("route_c", 1'b1, 1'b0, 2'b11, 1'b1, 1'b1);
    cycle("route_d", 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
    cycle("route_e", 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);

    // Back-pressure on out0 fills FIFO0; sel=1 still flows
    cycle("full_a", 1'b1, 1'b0, 2'b01, 1'b0, 1'b1);
    cycle("full_b", 1'b1, 1'b0, 2'b10, 1'b0, 1'b1);
    cycle("full_c", 1'b1, 1'b0, 2'b11, 1'b0, 1'b1);
    cycle("full_d", 1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
    cycle("full_e", 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);

    // Full FIFO0 with a pop in the same cycle: no accept until next cycle
    cycle("fpop_a", 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
    cycle("fpop_b", 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
    cycle("fpop_c", 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
    cycle("fpop_d", 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);

    // Pointer wrap on FIFO1
    for (int i = 0; i < 9; i++) cycle("wrap", 1'b1, 1'b1, W'(i % 4), 1'b0, 1'b1);
    cycle("wrap_end", 1'b0, 1'b1, 2'b00, 1'b1, 1'b1);
    cycle("wrap_end", 1'b0, 1'b1, 2'b00, 1'b1, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            W'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    end

    // Reset while FIFO0 holds two words
    do_reset("pre_fill");
    cycle("mid_a", 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    cycle("mid_b", 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    check("mid_full.out0_valid", bus.out0_valid, 1'b1);
    do_reset("mid_reset");
    cycle("post_reset", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

`ifdef Y_DEMUX_CNT_EN
    do_reset("cnt_reset");
    for (int i = 0; i < 257; i++) cycle("cnt", 1'b1, 1'b0, W'(i), 1'b1, 1'b0);
    cycle("cnt_drain", 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    cycle("cnt_drain", 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    check("cnt0_after_257", cnt0, 8'd1);
    check("cnt1_unchanged", cnt1, 8'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/y_demux2_buf.md
# y_demux2_buf

Buffered 1-to-2 demultiplexer for W-bit data with valid/ready handshakes. Accepts one word per cycle from a single input stream and routes it by `in_sel` into one of two independent FIFOs, each draining to its own output port. It is the receiving end of the `yMux2`-style 2:1 select path: a source selected onto a shared link is split back out to per-destination consumers. Back-pressure on one output never blocks traffic to the other.

## Interface
- `W`, 2: data width in bits (≥1).
- `DEPTH`, 2: entries per output FIFO (power of two, ≥2).

- `clk` input 1: single clock, rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `in_valid` input 1: input word present.
- `in_ready` output 1: selected FIFO can accept.
- `in_sel` input 1: destination, 0 → out0, 1 → out1.
- `in_data` input W: input word.
- `out0_valid` output 1: FIFO0 non-empty.
- `out0_ready` input 1: consumer 0 accepts.
- `out0_data` output W: FIFO0 head word.
- `out1_valid`, `out1_ready`, `out1_data`: same as above, for FIFO1.
- `cnt0`, `cnt1` output 8 each: pop counters (present only with `Y_DEMUX_CNT_EN`).

## Operation
- Each FIFO has a circular store of DEPTH×W bits, plus write and read pointers of log2(DEPTH)+1 bits.
  - Full: pointers differ only in the MSB.
  - Empty: pointers are equal.
  - Pointer index bits wrap DEPTH-1 → 0 and toggle the MSB.
- `in_ready` = ~full[`in_sel`]. It is combinational from `in_sel` and registered occupancy only, with no path from `outN_ready`.
- Push: `in_valid & in_ready` writes `in_data` at FIFO[`in_sel`] write pointer and increments that pointer.
- `outN_valid` = ~emptyN.
- `outN_data` = head entry when `outN_valid`=1, otherwise forced to 0.
- Pop N: `outN_valid & outN_ready` increments read pointer N.
- Push to one FIFO and pop from the other in the same cycle: both happen.
- Push and pop on the same non-full FIFO in the same cycle: both happen and occupancy is unchanged.
- Full FIFO with a pop in the same cycle: `in_ready`=0 for that FIFO. There is no pass-through, and the word is accepted the following cycle.
- Words leave each output in exactly their acceptance order. There is no ordering relation between out0 and out1.
- `in_valid`=0: `in_sel`/`in_data` are ignored, though `in_ready` still reflects the FIFO addressed by `in_sel`.
- Consumers holding `outN_ready`=0 must see `outN_data` stable until the pop.

## Timing
- Reset (asynchronous assert, release on the next clock edge):
  - All pointers 0.
  - `out0_valid`=`out1_valid`=0.
  - `out0_data`=`out1_data`=0.
  - `in_ready`=1.
  - `cnt0`=`cnt1`=0.
- Reset mid-operation discards all stored words immediately. Outputs take reset values without waiting for a clock.
- Latency: a word accepted at edge t appears on `outN_data` with `outN_valid`=1 after edge t (earliest pop at edge t+1).
- Throughput: 1 word/cycle on the input; each output drains 1 word/cycle.
- Occupancy ranges 0..DEPTH. `in_ready` for a FIFO falls in the cycle after the push that filled it.

## Configuration
- `Y_DEMUX_CNT_EN` defined: the `cnt0`/`cnt1` ports exist.
  - Each port is an 8-bit register that increments on every pop of its FIFO.
  - Wraps 255 → 0; reset to 0.
  - Counting never affects handshakes.
- Not defined: the ports and registers are absent, and all other behaviour is identical.

## Test plan
- Reset with W=2, DEPTH=2: assert `rstn`=0 mid-stream with FIFO0 holding 2 words → `out0_valid`=0 and `out0_data`=00 immediately; `in_ready`=1 after release.
- Routing: push 01 (sel 0), 10 (sel 1), 11 (sel 0) with both readies high → out0 yields 01 then 11, out1 yields 10; each word is visible one cycle after acceptance.
- Full/back-pressure: `out0_ready`=0, push 3 words to sel 0 → first two accepted; `in_ready`=0 on the third while sel=0. Switching to sel=1 raises `in_ready`=1 and the word reaches out1.
- Full with simultaneous pop: FIFO0 full, `out0_ready`=1, `in_valid`=1 sel 0 → no accept that cycle, accept next cycle; output order is preserved.
- Wrap-around: 9 consecutive push/pop pairs on FIFO1 with data cycling 00..11 → data matches in order, with no loss or duplication across pointer wrap.
- `Y_DEMUX_CNT_EN`: 257 pops on out0 → `cnt0`=1 and `cnt1` unchanged.
